// File: rtl/morse_char_scheduler.sv
// Character scheduler: queues ASCII bytes in a small FIFO and feeds them one
// at a time to the ASCII-to-Morse lookup and Morse signal generator, inserting
// inter-character and inter-word silence after each one.
module morse_char_scheduler #(
  parameter int FIFO_DEPTH     = 16,
  parameter int CLKS_PER_UNIT  = 2500000,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7
) (
  input  logic                            i_Clock,
  input  logic                            i_Rst_L,
  input  logic                            i_Char_DV,
  input  logic [7:0]                      i_Char,
  input  logic                            i_Flush,
  output logic [7:0]                      o_Char,
  input  logic                            i_Morse_Valid,
  output logic                            o_Morse_Start,
  input  logic                            i_Morse_Done,
  output logic                            o_Busy,
  output logic                            o_Empty,
  output logic                            o_Full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_Count,
  output logic                            o_Overflow,
  output logic                            o_Drop
);

  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_MAX = WORD_GAP_UNITS * CLKS_PER_UNIT;
  localparam int GW      = $clog2(GAP_MAX + 1);

  // Counter preloads are one less than the gap length so that the GAP state
  // lasts exactly the full number of clocks when counting down to zero.
  localparam logic [GW-1:0] CHAR_GAP_LOAD = GW'(CHAR_GAP_UNITS * CLKS_PER_UNIT - 1);
  localparam logic [GW-1:0] WORD_GAP_LOAD = GW'((WORD_GAP_UNITS - CHAR_GAP_UNITS) * CLKS_PER_UNIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_DISPATCH,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;
  logic            start_next;
  logic            drop_next;
  logic            gap_load;
  logic [GW-1:0]   gap_load_val;
  logic [GW-1:0]   gap_cnt;
  logic            gap_done;

  // A flush also swallows any byte pushed in the same cycle.
  assign push     = i_Char_DV && !o_Full && !i_Flush;
  assign gap_done = (gap_cnt == '0);
  assign o_Busy   = (state != ST_IDLE);

  // Next occupancy: flush wins, otherwise simultaneous push and pop cancel.
  always_comb begin
    count_next = o_Count;
    if (i_Flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = o_Count + CW'(1);
    end else if (pop && !push) begin
      count_next = o_Count - CW'(1);
    end
  end

  // Scheduler next-state logic: pop, settle lookup, dispatch, wait, then idle gap.
  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    start_next   = 1'b0;
    drop_next    = 1'b0;
    gap_load     = 1'b0;
    gap_load_val = CHAR_GAP_LOAD;
    case (state)
      ST_IDLE: begin
        if (!o_Empty) begin
          pop        = 1'b1;
          state_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        state_next = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        if (o_Char == 8'h20) begin
          gap_load     = 1'b1;
          gap_load_val = WORD_GAP_LOAD;
          state_next   = ST_GAP;
        end else if (i_Morse_Valid) begin
          start_next = 1'b1;
          state_next = ST_WAIT_DONE;
        end else begin
          drop_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_Morse_Done) begin
          gap_load   = 1'b1;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Gap timer: preloaded on entry to GAP and counted down to zero.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      gap_cnt <= '0;
    end else if (gap_load) begin
      gap_cnt <= gap_load_val;
    end else if (state == ST_GAP && !gap_done) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

  // FIFO pointers and registered occupancy flags.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_Count <= '0;
      o_Empty <= 1'b1;
      o_Full  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (i_Flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      o_Count <= count_next;
      o_Empty <= (count_next == '0);
      o_Full  <= (count_next == CW'(FIFO_DEPTH));
    end
  end

  // FIFO storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem[wr_ptr] <= i_Char;
    end
  end

  // Registered outputs: current character and one-cycle status pulses.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Char        <= 8'h00;
      o_Morse_Start <= 1'b0;
      o_Drop        <= 1'b0;
      o_Overflow    <= 1'b0;
    end else begin
      if (pop) begin
        o_Char <= mem[rd_ptr];
      end
      o_Morse_Start <= start_next;
      o_Drop        <= drop_next;
      o_Overflow    <= i_Char_DV && o_Full;
    end
  end

endmodule

// File: tb/tb_morse_char_scheduler.sv
// Bench for morse_char_scheduler: a timeline model of the scheduler (queue plus
// busy/pulse deadlines) checked every cycle, directed scenarios with literal
// expectations, then random typing with occasional flushes.
module tb_morse_char_scheduler;

  localparam int DEPTH      = 4;
  localparam int CPU        = 4;
  localparam int CHAR_GAP   = 3;
  localparam int WORD_GAP   = 7;
  localparam int DONE_DELAY = 10;
  localparam int CW         = $clog2(DEPTH + 1);

  logic          i_Clock = 1'b0;
  logic          i_Rst_L = 1'b1;
  logic          i_Char_DV = 1'b0;
  logic [7:0]    i_Char = 8'h00;
  logic          i_Flush = 1'b0;
  logic [7:0]    o_Char;
  logic          i_Morse_Valid;
  logic          o_Morse_Start;
  logic          i_Morse_Done = 1'b0;
  logic          o_Busy;
  logic          o_Empty;
  logic          o_Full;
  logic [CW-1:0] o_Count;
  logic          o_Overflow;
  logic          o_Drop;

  int checks = 0;
  int errors = 0;

  // Model state: queued bytes, current cycle index and scheduler deadlines.
  logic [7:0] q[$];
  int         cyc;
  int         busy_until;
  int         start_at;
  int         drop_at;
  bit         waiting;
  logic [7:0] exp_char;
  bit         exp_ovf;

  // Event log filled from observed outputs.
  int         n_starts = 0;
  int         n_drops = 0;
  int         n_dones = 0;
  int         n_ovf = 0;
  int         last_start = 0;
  int         last_done = 0;
  int         last_drop = 0;
  int         last_fall = 0;
  bit         drop_busy = 1'b0;
  bit         prev_busy = 1'b0;
  int         done_timer = 0;
  logic [7:0] start_log[$];

  morse_char_scheduler #(
    .FIFO_DEPTH    (DEPTH),
    .CLKS_PER_UNIT (CPU),
    .CHAR_GAP_UNITS(CHAR_GAP),
    .WORD_GAP_UNITS(WORD_GAP)
  ) dut (
    .i_Clock      (i_Clock),
    .i_Rst_L      (i_Rst_L),
    .i_Char_DV    (i_Char_DV),
    .i_Char       (i_Char),
    .i_Flush      (i_Flush),
    .o_Char       (o_Char),
    .i_Morse_Valid(i_Morse_Valid),
    .o_Morse_Start(o_Morse_Start),
    .i_Morse_Done (i_Morse_Done),
    .o_Busy       (o_Busy),
    .o_Empty      (o_Empty),
    .o_Full       (o_Full),
    .o_Count      (o_Count),
    .o_Overflow   (o_Overflow),
    .o_Drop       (o_Drop)
  );

  // Free-running clock.
  always #5 i_Clock = ~i_Clock;

  function automatic bit is_alnum(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A) || (c >= 8'h30 && c <= 8'h39);
  endfunction

  // Lookup stub: letters and digits have a Morse code, nothing else does.
  assign i_Morse_Valid = is_alnum(o_Char);

  task automatic checkOne(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic modelReset();
    q.delete();
    cyc        = 0;
    busy_until = 0;
    start_at   = -100;
    drop_at    = -100;
    waiting    = 1'b0;
    exp_char   = 8'h00;
    exp_ovf    = 1'b0;
  endtask

  // Advance the model over the cycle that just ended, using its inputs.
  task automatic modelStep();
    int k;
    int sz;
    bit busy_k;
    logic [7:0] ch;
    k      = cyc;
    sz     = q.size();
    busy_k = waiting || (k < busy_until);
    if (waiting && i_Morse_Done && k >= start_at) begin
      waiting    = 1'b0;
      busy_until = k + 1 + CHAR_GAP * CPU;
    end
    exp_ovf = i_Char_DV && (sz == DEPTH);
    if (!busy_k && sz > 0) begin
      ch       = q.pop_front();
      exp_char = ch;
      if (ch == 8'h20) begin
        busy_until = k + 3 + (WORD_GAP - CHAR_GAP) * CPU;
      end else if (is_alnum(ch)) begin
        waiting  = 1'b1;
        start_at = k + 3;
      end else begin
        drop_at    = k + 3;
        busy_until = k + 3;
      end
    end
    if (i_Flush) begin
      q.delete();
    end else if (i_Char_DV && sz < DEPTH) begin
      q.push_back(i_Char);
    end
    cyc = k + 1;
  endtask

  task automatic checkOutput();
    checkOne("o_Char",        int'(o_Char),        int'(exp_char));
    checkOne("o_Morse_Start", int'(o_Morse_Start), int'(cyc == start_at));
    checkOne("o_Drop",        int'(o_Drop),        int'(cyc == drop_at));
    checkOne("o_Busy",        int'(o_Busy),        int'(waiting || cyc < busy_until));
    checkOne("o_Count",       int'(o_Count),       q.size());
    checkOne("o_Empty",       int'(o_Empty),       int'(q.size() == 0));
    checkOne("o_Full",        int'(o_Full),        int'(q.size() == DEPTH));
    checkOne("o_Overflow",    int'(o_Overflow),    int'(exp_ovf));
  endtask

  // One clock cycle: step the model, compare, log, run the done stub, drive inputs.
  task automatic applyStimulus(input bit dv, input logic [7:0] ch, input bit fl);
    @(negedge i_Clock);
    modelStep();
    checkOutput();
    if (o_Morse_Start) begin
      n_starts++;
      last_start = cyc;
      start_log.push_back(o_Char);
    end
    if (o_Drop) begin
      n_drops++;
      last_drop = cyc;
      drop_busy = o_Busy;
    end
    if (o_Overflow) n_ovf++;
    if (prev_busy && !o_Busy) last_fall = cyc;
    prev_busy = o_Busy;
    i_Morse_Done = 1'b0;
    if (done_timer > 0) begin
      done_timer--;
      if (done_timer == 0) begin
        i_Morse_Done = 1'b1;
        n_dones++;
        last_done = cyc;
      end
    end
    if (o_Morse_Start) done_timer = DONE_DELAY;
    i_Char_DV = dv;
    i_Char    = ch;
    i_Flush   = fl;
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL timeout_%s at cycle %0d: event not seen, expected within budget", name, cyc);
  endtask

  task automatic waitStart(input int budget);
    int s0;
    s0 = n_starts;
    for (int i = 0; i < budget; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (n_starts != s0) return;
    end
    timeoutFail("start");
  endtask

  task automatic waitDone(input int budget);
    int d0;
    d0 = n_dones;
    for (int i = 0; i < budget; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (n_dones != d0) return;
    end
    timeoutFail("done");
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (!o_Busy && o_Empty && done_timer == 0) return;
    end
    timeoutFail("idle");
  endtask

  // Asynchronous reset away from any clock edge, with literal reset values.
  task automatic doReset();
    #2;
    i_Rst_L      = 1'b0;
    i_Char_DV    = 1'b0;
    i_Char       = 8'h00;
    i_Flush      = 1'b0;
    i_Morse_Done = 1'b0;
    done_timer   = 0;
    #1;
    checkOne("reset_o_Busy",        int'(o_Busy),        0);
    checkOne("reset_o_Empty",       int'(o_Empty),       1);
    checkOne("reset_o_Count",       int'(o_Count),       0);
    checkOne("reset_o_Char",        int'(o_Char),        0);
    checkOne("reset_o_Morse_Start", int'(o_Morse_Start), 0);
    checkOne("reset_o_Full",        int'(o_Full),        0);
    checkOne("reset_o_Drop",        int'(o_Drop),        0);
    checkOne("reset_o_Overflow",    int'(o_Overflow),    0);
    @(negedge i_Clock);
    @(negedge i_Clock);
    i_Rst_L = 1'b1;
    modelReset();
    prev_busy = 1'b0;
    checkOutput();
  endtask

  // Hard stop in case the run never reaches its summary.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int push_cyc;
    int a_done;
    int s0;
    int d0;
    int o0;
    int log0;
    string order;
    logic [7:0] tbl[8];
    bit dv;
    bit fl;

    tbl = '{8'h41, 8'h7A, 8'h37, 8'h20, 8'h23, 8'h51, 8'h21, 8'h30};
    modelReset();
    doReset();

    // Single valid character: start latency and gap length.
    s0 = n_starts;
    applyStimulus(1'b1, 8'h45, 1'b0);
    push_cyc = cyc;
    waitStart(20);
    checkOne("e_start_latency", last_start - push_cyc, 4);
    waitDone(30);
    waitIdle(40);
    checkOne("e_start_pulses", n_starts - s0, 1);
    checkOne("e_busy_after_done", last_fall - last_done - 1, 12);

    // 'A', space, 'B': gap 12, space pop/lookup/dispatch 3 + 16, B pop/lookup/dispatch/start 4.
    applyStimulus(1'b1, 8'h41, 1'b0);
    applyStimulus(1'b1, 8'h20, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0);
    waitStart(20);
    waitDone(30);
    a_done = last_done;
    waitStart(80);
    checkOne("b_start_after_a_done", last_start - a_done, 35);
    checkOne("b_start_char", int'(start_log[start_log.size() - 1]), 8'h42);
    waitIdle(60);

    // Reset in the middle of the inter-character gap.
    applyStimulus(1'b1, 8'h45, 1'b0);
    waitStart(20);
    waitDone(30);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOne("midgap_busy", int'(o_Busy), 1);
    doReset();

    // Overflow: six pushes into a four-entry FIFO while a blink is running.
    applyStimulus(1'b1, 8'h45, 1'b0);
    waitStart(20);
    o0   = n_ovf;
    log0 = start_log.size();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h41 + 8'(i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOne("ovf_count", int'(o_Count), 4);
    checkOne("ovf_full", int'(o_Full), 1);
    checkOne("ovf_pulses", n_ovf - o0, 2);
    waitIdle(400);
    order = "ABCD";
    checkOne("ovf_blinks", start_log.size() - log0, 4);
    for (int i = 0; i < 4; i++) begin
      if (log0 + i < start_log.size())
        checkOne("ovf_order", int'(start_log[log0 + i]), int'(order[i]));
    end

    // Invalid character is dropped without start or gap.
    s0 = n_starts;
    d0 = n_drops;
    applyStimulus(1'b1, 8'h23, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOne("drop_pulses", n_drops - d0, 1);
    checkOne("drop_no_start", n_starts - s0, 0);
    checkOne("drop_busy_low", int'(drop_busy), 0);
    checkOne("drop_no_gap", last_fall, last_drop);

    // Flush during the first of three queued blinks.
    applyStimulus(1'b1, 8'h4B, 1'b0);
    applyStimulus(1'b1, 8'h4D, 1'b0);
    applyStimulus(1'b1, 8'h4E, 1'b0);
    waitStart(20);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOne("flush_count", int'(o_Count), 0);
    s0 = n_starts;
    waitIdle(60);
    checkOne("flush_no_more_starts", n_starts - s0, 0);
    checkOne("flush_gap_kept", last_fall - last_done - 1, 12);
    checkOne("flush_last_char", int'(start_log[start_log.size() - 1]), 8'h4B);

    // Random typing with occasional flushes.
    for (int i = 0; i < 2500; i++) begin
      dv = ($urandom_range(0, 99) < 25);
      fl = ($urandom_range(0, 199) == 0);
      applyStimulus(dv, tbl[$urandom_range(0, 7)], fl);
    end
    waitIdle(800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
